// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : MEM pipeline stage. Passes ALU results straight through to
//                the MEM/WB registers and runs LW/SW on a req/ack data bus.
//                The pipeline is stalled while a bus access is outstanding,
//                and an access with no ack is aborted after TIMEOUT cycles.
//                Optional feature macro: MEM_ALIGN_CHECK_EN (reject
//                misaligned word accesses instead of truncating the address).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [4:0]  waddr_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] reg2_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_sel_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  waddr_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        bus_err_o,
  output logic        align_err_o
);

  localparam logic [7:0] c_EXE_LW_OP = 8'b1110_0011;
  localparam logic [7:0] c_EXE_SW_OP = 8'b1110_1011;
  localparam int         c_CW        = $clog2(TIMEOUT);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_sel;
  logic [4:0]        r_lat_waddr;
  logic              r_lat_wreg;

  logic              r_wb_valid;
  logic [4:0]        r_waddr;
  logic              r_wreg;
  logic [31:0]       r_wdata;
  logic              r_bus_err;
  logic              r_align_err;

  logic              w_is_mem;
  logic              w_misalign;
  logic              w_cnt_last;
  logic              w_stall;
  logic              w_issue;
  logic              w_pass;
  logic              w_bad_align;
  logic              w_done;
  logic              w_abort;

  assign w_is_mem   = valid_i & ((aluop_i == c_EXE_LW_OP) | (aluop_i == c_EXE_SW_OP));
  assign w_cnt_last = (r_cnt == c_CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_is_mem & (wdata_i[1:0] != 2'b00);
`else
  // Low address bits are simply dropped when the word address is formed.
  assign w_misalign = 1'b0;
`endif

  // Next-state and per-cycle event decode; ack beats timeout in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_issue     = 1'b0;
    w_pass      = 1'b0;
    w_bad_align = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem && !w_misalign) begin
          w_issue     = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = S_BUSY;
        end else if (w_is_mem) begin
          w_bad_align = 1'b1;
        end else if (valid_i) begin
          w_pass      = 1'b1;
        end
      end
      S_BUSY: begin
        if (mem_ack_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_cnt_last) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Timeout counter: cleared on issue, advances on each ack-less BUSY cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= '0;
    end else if ((r_state == S_BUSY) && !mem_ack_i && !w_cnt_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Bus request and transaction fields, held stable until completion/abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_sel   <= '0;
      r_lat_waddr <= '0;
      r_lat_wreg  <= 1'b0;
    end else if (w_issue) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= (aluop_i == c_EXE_SW_OP);
      r_mem_addr  <= {wdata_i[31:2], 2'b00};
      r_mem_wdata <= reg2_i;
      r_mem_sel   <= 4'b1111;
      r_lat_waddr <= waddr_i;
      r_lat_wreg  <= wreg_i;
    end else if (w_done || w_abort) begin
      r_mem_req   <= 1'b0;
    end
  end

  // MEM/WB writeback fields and single-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_valid  <= 1'b0;
      r_waddr     <= '0;
      r_wreg      <= 1'b0;
      r_wdata     <= '0;
      r_bus_err   <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_align_err <= 1'b0;
      if (w_pass) begin
        r_wb_valid <= 1'b1;
        r_waddr    <= waddr_i;
        r_wreg     <= wreg_i;
        r_wdata    <= wdata_i;
      end else if (w_bad_align) begin
        r_wb_valid  <= 1'b1;
        r_waddr     <= waddr_i;
        r_wreg      <= 1'b0;
        r_wdata     <= '0;
        r_align_err <= 1'b1;
      end else if (w_done) begin
        r_wb_valid <= 1'b1;
        r_waddr    <= r_lat_waddr;
        r_wreg     <= r_lat_wreg & ~r_mem_we;
        r_wdata    <= r_mem_we ? 32'd0 : mem_rdata_i;
      end else if (w_abort) begin
        r_wb_valid <= 1'b1;
        r_waddr    <= r_lat_waddr;
        r_wreg     <= 1'b0;
        r_wdata    <= '0;
        r_bus_err  <= 1'b1;
      end
    end
  end

  assign stall_o     = w_stall;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_sel_o   = r_mem_sel;
  assign wb_valid_o  = r_wb_valid;
  assign waddr_o     = r_waddr;
  assign wreg_o      = r_wreg;
  assign wdata_o     = r_wdata;
  assign bus_err_o   = r_bus_err;
  assign align_err_o = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Self-checking bench for mem_access. Instructions are applied
//                one at a time; a transaction-level model predicts the bus
//                request, stall behaviour and writeback for each one.
//                Honours MEM_ALIGN_CHECK_EN in the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  localparam int         c_TO    = 16;
  localparam logic [7:0] c_LW_OP = 8'b1110_0011;
  localparam logic [7:0] c_SW_OP = 8'b1110_1011;
  localparam logic [7:0] c_ADD   = 8'b0010_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  aluop_i;
  logic [4:0]  waddr_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] reg2_i;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_sel_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  waddr_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        bus_err_o;
  logic        align_err_o;

  int n_vec = 0;
  int n_err = 0;

  mem_access #(.TIMEOUT(c_TO)) u_dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
    .waddr_i(waddr_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .reg2_i(reg2_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .waddr_o(waddr_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .bus_err_o(bus_err_o), .align_err_o(align_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One cycle with no valid instruction; optionally a stray ack on the bus.
  task automatic idle_cycle(input logic stray_ack);
    valid_i     = 1'b0;
    mem_ack_i   = stray_ack;
    mem_rdata_i = $urandom;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    chk("idle_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("idle_mem_req",  {31'd0, mem_req_o},  32'd0);
    chk("idle_bus_err",  {31'd0, bus_err_o},  32'd0);
  endtask

  // Apply one instruction (called just after a rising edge). lat = BUSY
  // cycle on which the bus acks (1-based); any value above c_TO means never.
  task automatic do_instr(input logic [7:0] op, input logic [4:0] wa, input logic we,
                          input logic [31:0] wd, input logic [31:0] r2, input int lat);
    logic        is_mem, is_st, misal, acked, done;
    logic [31:0] rdata;
    int          k;
    is_mem = (op == c_LW_OP) || (op == c_SW_OP);
    is_st  = (op == c_SW_OP);
    misal  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal  = is_mem && (wd[1:0] != 2'b00);
`endif
    valid_i = 1'b1; aluop_i = op; waddr_i = wa; wreg_i = we; wdata_i = wd; reg2_i = r2;
    @(negedge clk);
    if (!is_mem || misal) begin
      chk("stall_nomem", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      chk("pass_wb_valid",  {31'd0, wb_valid_o},  32'd1);
      chk("pass_mem_req",   {31'd0, mem_req_o},   32'd0);
      chk("pass_align_err", {31'd0, align_err_o}, {31'd0, misal});
      chk("pass_bus_err",   {31'd0, bus_err_o},   32'd0);
      chk("pass_wreg",      {31'd0, wreg_o},      {31'd0, we & ~misal});
      if (!misal) begin
        chk("pass_waddr", {27'd0, waddr_o}, {27'd0, wa});
        chk("pass_wdata", wdata_o, wd);
      end
    end else begin
      chk("stall_issue", {31'd0, stall_o}, 32'd1);
      rdata = $urandom;
      k     = 0;
      done  = 1'b0;
      acked = 1'b0;
      while (!done) begin
        @(posedge clk); #1;
        k++;
        chk("busy_req",      {31'd0, mem_req_o},  32'd1);
        chk("busy_we",       {31'd0, mem_we_o},   {31'd0, is_st});
        chk("busy_addr",     mem_addr_o,          {wd[31:2], 2'b00});
        chk("busy_sel",      {28'd0, mem_sel_o},  32'hF);
        chk("busy_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        if (is_st) chk("busy_wdata", mem_wdata_o, r2);
        acked       = (k == lat);
        mem_ack_i   = acked;
        mem_rdata_i = acked ? rdata : $urandom;
        @(negedge clk);
        chk("busy_stall", {31'd0, stall_o}, {31'd0, !acked && (k < c_TO)});
        if (acked || (k == c_TO)) done = 1'b1;
      end
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      chk("done_wb_valid",  {31'd0, wb_valid_o},  32'd1);
      chk("done_mem_req",   {31'd0, mem_req_o},   32'd0);
      chk("done_bus_err",   {31'd0, bus_err_o},   {31'd0, !acked});
      chk("done_align_err", {31'd0, align_err_o}, 32'd0);
      chk("done_wreg",      {31'd0, wreg_o},      {31'd0, acked && !is_st && we});
      if (acked && !is_st && we) begin
        chk("done_waddr", {27'd0, waddr_o}, {27'd0, wa});
        chk("done_rdata", wdata_o, rdata);
      end
    end
    valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] wd;
    int          kind;
    rst = 1'b0; valid_i = 1'b0; aluop_i = '0; waddr_i = '0; wreg_i = 1'b0;
    wdata_i = '0; reg2_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;

    // Reset held for two edges: every output low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall",    {31'd0, stall_o},    32'd0);
    chk("rst_mem_req",  {31'd0, mem_req_o},  32'd0);
    chk("rst_mem_we",   {31'd0, mem_we_o},   32'd0);
    chk("rst_mem_addr", mem_addr_o,          32'd0);
    chk("rst_mem_sel",  {28'd0, mem_sel_o},  32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_wdata",    wdata_o,             32'd0);
    chk("rst_bus_err",  {31'd0, bus_err_o},  32'd0);
    chk("rst_align",    {31'd0, align_err_o}, 32'd0);
    rst = 1'b1;
    idle_cycle(1'b0);

    // Directed cases.
    do_instr(c_ADD,   5'd3, 1'b1, 32'h0000_1234, 32'h0, 1);
    do_instr(c_LW_OP, 5'd5, 1'b1, 32'h0000_0100, 32'h0, 3);
    do_instr(c_SW_OP, 5'd7, 1'b0, 32'h0000_0104, 32'hA5A5_A5A5, c_TO + 5);
    idle_cycle(1'b1);                                   // late ack after abort
    do_instr(c_SW_OP, 5'd1, 1'b0, 32'h0000_0200, 32'h1111_2222, 1);
    do_instr(c_LW_OP, 5'd9, 1'b1, 32'h0000_0204, 32'h0, 1);
    do_instr(c_LW_OP, 5'd4, 1'b1, 32'h0000_0300, 32'h0, c_TO); // ack on last cycle
    do_instr(c_LW_OP, 5'd6, 1'b1, 32'h0000_0102, 32'h0, 2);    // misaligned
    idle_cycle(1'b0);

    // Reset while BUSY: request drops on the next edge, no writeback.
    valid_i = 1'b1; aluop_i = c_LW_OP; waddr_i = 5'd2; wreg_i = 1'b1;
    wdata_i = 32'h0000_0400;
    @(posedge clk); #1;
    chk("rstb_req_before", {31'd0, mem_req_o}, 32'd1);
    rst = 1'b0; valid_i = 1'b0;
    @(posedge clk); #1;
    chk("rstb_mem_req",  {31'd0, mem_req_o},  32'd0);
    chk("rstb_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    @(negedge clk);
    chk("rstb_stall", {31'd0, stall_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Randomized instruction stream.
    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 3);
      wd   = $urandom;
      if (kind == 0) begin
        op = 8'($urandom);
        if (op == c_LW_OP || op == c_SW_OP) op = op ^ 8'h01;
      end else begin
        op = (kind == 1) ? c_SW_OP : c_LW_OP;
        if ($urandom_range(0, 3) != 0) wd[1:0] = 2'b00;
      end
      if (kind == 3) idle_cycle($urandom_range(0, 1) == 1);
      do_instr(op, 5'($urandom), 1'($urandom), wd, $urandom, $urandom_range(1, c_TO + 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
